// File: rtl/mem_word_ctrl_if.sv
// Request/response bundle between a requester and mem_word_ctrl.
//   master : drives req_valid/req_rw/req_size/req_addr/req_wdata,
//            receives req_ready/resp_valid/resp_rdata/addr_error.
//   slave  : the controller side (directions reversed).
//   req_rw   1 = read, 0 = write
//   req_size 0 = byte, 1 = 32-bit word
interface mem_word_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic        req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_error;

  modport master (
    output req_valid, req_rw, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, addr_error
  );

  modport slave (
    input  req_valid, req_rw, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, addr_error
  );
endinterface

// File: rtl/mem_word_ctrl.sv
// Byte/word access controller in front of a 256x8 RAM (ram256x8 style port).
// A word request is split into four byte accesses at base..base+3; every byte
// access is one SETUP cycle (address/direction/data settled, enable low)
// followed by one STROBE cycle (enable high, same values).
//
// Ports
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   req        : request/response bundle (slave modport of mem_word_ctrl_if)
//   enable     : RAM chip enable
//   read_write : RAM direction, 1 = read, 0 = write (1 whenever idle)
//   address    : RAM byte address (holds its last value between accesses)
//   data_in    : RAM write byte (holds its last value between accesses)
//   data_out   : RAM read byte, combinational while enable=1 and read_write=1
//
// Parameter
//   BIG_ENDIAN : 1 = byte at the word address sits in bits 31:24,
//                0 = byte at the word address sits in bits 7:0
module mem_word_ctrl #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_word_ctrl_if.slave req,
  output logic           enable,
  output logic           read_write,
  output logic [7:0]     address,
  output logic [7:0]     data_in,
  input  logic [7:0]     data_out
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t      state_q, state_d;
  logic        rw_q;
  logic        size_q;
  logic [1:0]  cnt_q;       // byte offset within the current word
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        addr_err_q;

  logic        accept;
  logic        misaligned;
  logic        last_byte;

  // Physical lane (0 = bits 7:0) used for byte offset k of a word.
  function automatic logic [1:0] lane_of(input logic [1:0] k);
    return BIG_ENDIAN ? ~k : k;
  endfunction

  function automatic logic [7:0] lane_get(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (lane_of(k))
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane_of(k))
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  assign accept     = (state_q == IDLE) && req.req_valid;
  assign misaligned = req.req_size && (req.req_addr[1:0] != 2'b00);
  assign last_byte  = !size_q || (cnt_q == 2'd3);

  always_comb begin
    state_d        = state_q;
    enable         = 1'b0;
    read_write     = 1'b1;
    req.req_ready  = 1'b0;
    req.resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) state_d = misaligned ? DONE : SETUP;
      end
      SETUP: begin
        read_write = rw_q;
        state_d    = STROBE;
      end
      STROBE: begin
        enable     = 1'b1;
        read_write = rw_q;
        state_d    = last_byte ? DONE : SETUP;
      end
      DONE: begin
        req.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req.resp_rdata = rdata_q;
  assign req.addr_error = addr_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rw_q       <= 1'b1;
      size_q     <= 1'b0;
      cnt_q      <= 2'd0;
      address    <= 8'd0;
      data_in    <= 8'd0;
      rdata_q    <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rw_q       <= req.req_rw;
        size_q     <= req.req_size;
        cnt_q      <= 2'd0;
        rdata_q    <= 32'd0;
        addr_err_q <= misaligned;
        // A rejected (misaligned) request never touches the RAM port, so
        // address/data_in keep whatever the previous access left there.
        if (!misaligned) begin
          address <= req.req_addr;
          data_in <= req.req_size ? lane_get(req.req_wdata, 2'd0) : req.req_wdata[7:0];
        end
      end else if (state_q == STROBE) begin
        // The read byte is taken on the edge that closes the strobe.
        if (rw_q) begin
          rdata_q <= size_q ? lane_put(rdata_q, cnt_q, data_out) : {24'd0, data_out};
        end
        if (!last_byte) begin
          cnt_q   <= cnt_q + 2'd1;
          address <= address + 8'd1;
          data_in <= lane_get(wdata_q, cnt_q + 2'd1);
        end
      end
    end
  end

  // Write data is only consumed while an access is running, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= req.req_wdata;
  end

endmodule

// File: tb/tb_mem_word_ctrl.sv
module tb_mem_word_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_rw    = 1'b1;
  logic        req_size  = 1'b0;
  logic [7:0]  req_addr  = 8'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        pre_we    = 1'b0;
  logic [7:0]  pre_addr  = 8'd0;
  logic [7:0]  pre_data  = 8'd0;

  int checks = 0;
  int errors = 0;

  mem_word_ctrl_if ifc_le();
  mem_word_ctrl_if ifc_be();

  assign ifc_le.req_valid = req_valid;
  assign ifc_le.req_rw    = req_rw;
  assign ifc_le.req_size  = req_size;
  assign ifc_le.req_addr  = req_addr;
  assign ifc_le.req_wdata = req_wdata;
  assign ifc_be.req_valid = req_valid;
  assign ifc_be.req_rw    = req_rw;
  assign ifc_be.req_size  = req_size;
  assign ifc_be.req_addr  = req_addr;
  assign ifc_be.req_wdata = req_wdata;

  logic       en_le, rw_le, en_be, rw_be;
  logic [7:0] ad_le, di_le, do_le, ad_be, di_be, do_be;
  logic [7:0] ram [2][256];   // [0] behind little-endian DUT, [1] behind big-endian DUT

  mem_word_ctrl #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset_n(reset_n), .req(ifc_le),
    .enable(en_le), .read_write(rw_le), .address(ad_le), .data_in(di_le), .data_out(do_le)
  );

  mem_word_ctrl #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset_n(reset_n), .req(ifc_be),
    .enable(en_be), .read_write(rw_be), .address(ad_be), .data_in(di_be), .data_out(do_be)
  );

  // RAM models: combinational read, write on the rising edge that ends a write strobe.
  assign do_le = ram[0][ad_le];
  assign do_be = ram[1][ad_be];
  always @(posedge clk) begin
    if (pre_we) begin
      ram[0][pre_addr] <= pre_data;
      ram[1][pre_addr] <= pre_data;
    end else begin
      if (en_le && !rw_le) ram[0][ad_le] <= di_le;
      if (en_be && !rw_be) ram[1][ad_be] <= di_be;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One request is described by its timeline: t counts clock edges since the
  // accepting edge. Byte k of an n-byte access is set up at t=2k+1, strobed at
  // t=2k+2 and written to memory on the edge that makes t=2k+3; the response is
  // shown at t=2n+1 (t=1 for a rejected word request), then the block is idle.
  bit          m_busy = 1'b0;
  bit          m_err  = 1'b0;
  bit          m_rw   = 1'b1;
  bit          m_size = 1'b0;
  int          m_t    = 0;
  int          m_n    = 0;
  int          m_done = 0;
  logic [7:0]  m_base = 8'd0;
  logic [7:0]  m_hold = 8'd0;   // address the RAM port is expected to show
  logic [31:0] m_w    = 32'd0;
  logic [31:0] m_exp [2];
  logic [7:0]  shadow [2][256];

  // Byte i of the write data as it must reach memory address base+i.
  function automatic logic [7:0] exp_wbyte(input int k, input int i);
    if (!m_size) return m_w[7:0];
    if (k == 1) return m_w[8*(3-i) +: 8];
    return m_w[8*i +: 8];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (pre_we && reset_n == 1'b0) begin
      shadow[0][pre_addr] = pre_data;
      shadow[1][pre_addr] = pre_data;
    end
    if (!reset_n) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_hold = 8'd0;
    end else if (m_busy) begin
      m_t++;
      if (!m_err && !m_rw && m_t >= 3 && (m_t % 2 == 1) && m_t <= 2*m_n + 1) begin
        for (int k = 0; k < 2; k++)
          shadow[k][m_base + 8'((m_t-3)/2)] = exp_wbyte(k, (m_t-3)/2);
      end
      if (!m_err && m_t <= 2*m_n) m_hold = m_base + 8'((m_t-1)/2);
      if (m_t > m_done) m_busy = 1'b0;
    end else if (req_valid) begin
      m_rw   = req_rw;
      m_size = req_size;
      m_base = req_addr;
      m_w    = req_wdata;
      m_err  = req_size && (req_addr % 4 != 0);
      m_n    = req_size ? 4 : 1;
      m_done = m_err ? 1 : 2*m_n + 1;
      m_t    = 1;
      m_busy = 1'b1;
      if (m_err || !m_rw) begin
        m_exp[0] = 32'd0;
        m_exp[1] = 32'd0;
      end else if (!m_size) begin
        m_exp[0] = {24'd0, shadow[0][m_base]};
        m_exp[1] = {24'd0, shadow[1][m_base]};
      end else begin
        m_exp[0] = {shadow[0][m_base+8'd3], shadow[0][m_base+8'd2],
                    shadow[0][m_base+8'd1], shadow[0][m_base]};
        m_exp[1] = {shadow[1][m_base], shadow[1][m_base+8'd1],
                    shadow[1][m_base+8'd2], shadow[1][m_base+8'd3]};
      end
      if (!m_err) m_hold = m_base;
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_one(input string tag, input int k, input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic ae, input logic en,
                         input logic rw, input logic [7:0] ad, input logic [7:0] di);
    bit acc, done;
    acc  = m_busy && !m_err && (m_t <= 2*m_n);
    done = m_busy && (m_t == m_done);
    chk({tag, "_req_ready"}, 32'(rdy), 32'(!m_busy));
    chk({tag, "_resp_valid"}, 32'(rv), 32'(done));
    if (done) begin
      chk({tag, "_resp_rdata"}, rd, m_exp[k]);
      chk({tag, "_addr_error"}, 32'(ae), 32'(m_err));
    end
    chk({tag, "_enable"}, 32'(en), 32'(acc && (m_t % 2 == 0)));
    chk({tag, "_read_write"}, 32'(rw), 32'(acc ? m_rw : 1'b1));
    chk({tag, "_address"}, 32'(ad), 32'(m_hold));
    if (acc && !m_rw) chk({tag, "_data_in"}, 32'(di), 32'(exp_wbyte(k, (m_t-1)/2)));
    if (!reset_n) begin
      chk({tag, "_rst_data_in"}, 32'(di), 32'd0);
      chk({tag, "_rst_rdata"}, rd, 32'd0);
      chk({tag, "_rst_addr_error"}, 32'(ae), 32'd0);
    end
  endtask

  int en_cnt   = 0;   // strobe cycles seen on the little-endian RAM port
  int low_run  = 0;
  int last_low = 0;   // length of the last completed req_ready=0 stretch

  always @(negedge clk) begin
    cmp_one("le", 0, ifc_le.req_ready, ifc_le.resp_valid, ifc_le.resp_rdata, ifc_le.addr_error,
            en_le, rw_le, ad_le, di_le);
    cmp_one("be", 1, ifc_be.req_ready, ifc_be.resp_valid, ifc_be.resp_rdata, ifc_be.addr_error,
            en_be, rw_be, ad_be, di_be);
    if (en_le) en_cnt++;
    if (!ifc_le.req_ready) low_run++;
    else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!ifc_le.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, n < 50}, 32'd1);
  endtask

  // Issue one request from a falling edge; returns the response and the number
  // of falling edges from the accepting edge to the one showing resp_valid.
  task automatic xact(input logic rw, input logic size, input logic [7:0] a,
                      input logic [31:0] wd, output logic [31:0] rd_le,
                      output logic [31:0] rd_be, output logic ae, output int lat);
    req_valid = 1'b1; req_rw = rw; req_size = size; req_addr = a; req_wdata = wd;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    // Scramble the request fields after acceptance; they must not matter now.
    req_valid = 1'b0; req_rw = ~rw; req_size = ~size; req_addr = ~a; req_wdata = ~wd;
    lat = 1;
    while (!ifc_le.resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_wait", {31'd0, lat < 50}, 32'd1);
    rd_le = ifc_le.resp_rdata;
    rd_be = ifc_be.resp_rdata;
    ae    = ifc_le.addr_error;
    @(negedge clk);
  endtask

  task automatic scan_mem(input string nm);
    int bad;
    bad = 0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++)
        if (ram[k][a] !== shadow[k][a]) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  logic [31:0] r_le, r_be;
  logic        r_ae;
  int          lat, e0, seen, t;

  initial begin
    #1 reset_n = 1'b0;
    @(negedge clk);
    pre_we = 1'b1;
    for (int a = 0; a < 256; a++) begin
      pre_addr = 8'(a);
      pre_data = 8'(a) ^ 8'h5A;
      @(negedge clk);
    end
    pre_addr = 8'h10; pre_data = 8'h11; @(negedge clk);
    pre_addr = 8'h11; pre_data = 8'h22; @(negedge clk);
    pre_addr = 8'h12; pre_data = 8'h33; @(negedge clk);
    pre_addr = 8'h13; pre_data = 8'h44; @(negedge clk);
    pre_addr = 8'hFF; pre_data = 8'h7E; @(negedge clk);
    pre_we  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_ready", 32'(ifc_le.req_ready), 32'd1);
    chk("rst_enable", 32'(en_be), 32'd0);
    chk("rst_read_write", 32'(rw_le), 32'd1);
    chk("rst_address", 32'(ad_be), 32'd0);
    chk("rst_data_in", 32'(di_le), 32'd0);
    chk("rst_resp_valid", 32'(ifc_be.resp_valid), 32'd0);
    scan_mem("mem_preload");

    // word read, both lane orders
    xact(1'b1, 1'b1, 8'h10, 32'h0, r_le, r_be, r_ae, lat);
    chk("wrd_be_data", r_be, 32'h11223344);
    chk("wrd_le_data", r_le, 32'h44332211);
    chk("wrd_latency", 32'(lat), 32'd9);

    // word write
    e0 = en_cnt;
    xact(1'b0, 1'b1, 8'h20, 32'hA1B2C3D4, r_le, r_be, r_ae, lat);
    chk("wwr_strobes", 32'(en_cnt - e0), 32'd4);
    chk("wwr_rdata", r_le, 32'd0);
    chk("wwr_le_20", 32'(ram[0][8'h20]), 32'hD4);
    chk("wwr_le_21", 32'(ram[0][8'h21]), 32'hC3);
    chk("wwr_le_22", 32'(ram[0][8'h22]), 32'hB2);
    chk("wwr_le_23", 32'(ram[0][8'h23]), 32'hA1);
    chk("wwr_be_20", 32'(ram[1][8'h20]), 32'hA1);
    chk("wwr_be_23", 32'(ram[1][8'h23]), 32'hD4);

    // byte read at the top address
    xact(1'b1, 1'b0, 8'hFF, 32'h0, r_le, r_be, r_ae, lat);
    chk("brd_le_data", r_le, 32'h0000007E);
    chk("brd_be_data", r_be, 32'h0000007E);
    chk("brd_latency", 32'(lat), 32'd3);

    // byte write touches one location only
    xact(1'b0, 1'b0, 8'h03, 32'hFFFFFF5A, r_le, r_be, r_ae, lat);
    chk("bwr_03", 32'(ram[0][8'h03]), 32'h5A);
    chk("bwr_02", 32'(ram[1][8'h02]), 32'h58);
    chk("bwr_04", 32'(ram[0][8'h04]), 32'h5E);
    scan_mem("mem_after_writes");

    // misaligned word request
    e0 = en_cnt;
    xact(1'b1, 1'b1, 8'h42, 32'h0, r_le, r_be, r_ae, lat);
    chk("mis_error", 32'(r_ae), 32'd1);
    chk("mis_rdata", r_be, 32'd0);
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_no_strobe", 32'(en_cnt - e0), 32'd0);

    // read back written word and one byte of it
    xact(1'b1, 1'b1, 8'h20, 32'h0, r_le, r_be, r_ae, lat);
    chk("rb_le", r_le, 32'hA1B2C3D4);
    chk("rb_be", r_be, 32'hA1B2C3D4);
    xact(1'b1, 1'b0, 8'h21, 32'h0, r_le, r_be, r_ae, lat);
    chk("rb_byte_le", r_le, 32'h000000C3);
    chk("rb_byte_be", r_be, 32'h000000B2);

    // back-to-back word reads with req_valid held high
    req_valid = 1'b1; req_rw = 1'b1; req_size = 1'b1; req_addr = 8'h10;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!ifc_le.resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_resp", r_be, r_be);
    chk("b2b_data", ifc_be.resp_rdata, 32'h11223344);
    repeat (3) @(negedge clk);
    chk("b2b_ready_low", 32'(last_low), 32'd9);

    // reset during the third byte of a word write
    req_valid = 1'b1; req_rw = 1'b0; req_size = 1'b1; req_addr = 8'h30; req_wdata = 32'hCAFEF00D;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t = 1;
    while (t < 6) begin
      @(negedge clk);
      t++;
    end
    chk("abort_strobe", 32'(en_le), 32'd1);
    chk("abort_addr", 32'(ad_be), 32'h32);
    #1 reset_n = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifc_le.resp_valid || ifc_be.resp_valid) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    chk("abort_le_30", 32'(ram[0][8'h30]), 32'h0D);
    chk("abort_le_31", 32'(ram[0][8'h31]), 32'hF0);
    chk("abort_le_32", 32'(ram[0][8'h32]), 32'h68);
    chk("abort_le_33", 32'(ram[0][8'h33]), 32'h69);
    chk("abort_be_30", 32'(ram[1][8'h30]), 32'hCA);
    chk("abort_be_31", 32'(ram[1][8'h31]), 32'hFE);
    chk("abort_be_32", 32'(ram[1][8'h32]), 32'h68);
    chk("abort_address", 32'(ad_le), 32'd0);
    chk("abort_data_in", 32'(di_be), 32'd0);
    chk("abort_read_write", 32'(rw_le), 32'd1);
    chk("abort_ready", 32'(ifc_be.req_ready), 32'd1);
    scan_mem("mem_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
